// File: rtl/axrm_seq_mul_ctrl.sv
// Sequential 8x8 approximate recursive multiplier: one shared 2x2 digit cell steps through
// all 16 digit pairs and accumulates the shifted partial products into a 16-bit result.
module axrm_seq_mul_ctrl #(
  parameter int APPROX_ROWS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic        mode_q;
  logic [3:0]  k;
  logic [15:0] acc;

  logic        accept;
  logic [1:0]  di, dj, x, y;
  logic        use_approx;
  logic [3:0]  p;
  logic [2:0]  dsum;
  logic [3:0]  shamt;
  logic [15:0] term, acc_sum;

  // Digit selection and the shared 2x2 cell; rows below APPROX_ROWS degrade to the 3-bit cell.
  always_comb begin
    di         = k[3:2];
    dj         = k[1:0];
    x          = 2'(a_q >> {di, 1'b0});
    y          = 2'(b_q >> {dj, 1'b0});
    use_approx = mode_q && ({1'b0, di} < 3'(APPROX_ROWS));
    if (use_approx)
      p = {1'b0, x[1] & y[1], x[0] & y[0], x[0] & y[0]};
    else
      p = {2'b00, x} * {2'b00, y};
    dsum    = {1'b0, di} + {1'b0, dj};
    shamt   = {dsum, 1'b0};
    term    = 16'(p) << shamt;
    acc_sum = acc + term;
  end

  // Ready is forced low while reset is held so nothing can be accepted during reset.
  always_comb begin
    state_nxt = state;
    in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state == DONE);
    busy      = (state == RUN);
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (k == 4'd15) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, accumulation, and result publication on the final digit product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      k      <= '0;
      acc    <= '0;
      Y      <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      k      <= '0;
      acc    <= '0;
    end else if (state == RUN) begin
      acc <= acc_sum;
      k   <= k + 4'd1;
      if (k == 4'd15) Y <= acc_sum;
    end
  end

endmodule

// File: tb/tb_axrm_seq_mul_ctrl.sv
// Directed bench for axrm_seq_mul_ctrl: reset, exact/approx products, handshake, reset abort.
module tb_axrm_seq_mul_ctrl;

  localparam int AR = 3;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] Y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axrm_seq_mul_ctrl #(.APPROX_ROWS(AR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference product built digit by digit from the cell definitions.
  function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mm);
    int sum, x, y, p;
    sum = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        x = (int'(ma) >> (2 * i)) & 3;
        y = (int'(mb) >> (2 * j)) & 3;
        if (mm && i < AR) p = ((x >> 1) & (y >> 1)) * 4 + (x & y & 1) * 3;
        else              p = x * y;
        sum += p * (1 << (2 * (i + j)));
      end
    return 16'(sum);
  endfunction

  // Offer an operand pair and return just after the accept edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic tm);
    int waits;
    in_valid = 1'b1; a = ta; b = tb; mode = tm;
    #1;
    waits = 0;
    while (!in_ready && waits < 50) begin step(); waits++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL issue_timeout: in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); mode = ~tm;
  endtask

  // Edges counted from the accept edge (=1) until out_valid; 17 means DONE after 16 RUN cycles.
  task automatic wait_result(output int edges);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin step(); edges++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0;
    step(); step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (Y !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_y: got %h expected 0000", Y); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    step();
  endtask

  task automatic test_exact();
    int lat;
    issue(8'd255, 8'd255, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL exact_busy: got %b expected 1", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL exact_in_ready_run: got %b expected 0", in_ready); end
    wait_result(lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL exact_latency: got %0d expected 17", lat); end
    n_checks++; if (Y !== 16'hFE01) begin n_fail++; $display("[TB] FAIL exact_y: got %h expected fe01", Y); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL exact_busy_done: got %b expected 0", busy); end
    consume();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL exact_consumed: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL exact_idle_ready: got %b expected 1", in_ready); end
    n_checks++; if (Y !== 16'hFE01) begin n_fail++; $display("[TB] FAIL exact_y_hold: got %h expected fe01", Y); end
  endtask

  task automatic test_approx();
    logic [7:0]  va [3] = '{8'd255, 8'd3, 8'd1};
    logic [7:0]  vb [3] = '{8'd255, 8'd3, 8'd1};
    logic [15:0] ve [3] = '{16'hF00F, 16'd7, 16'd3};
    int lat;
    for (int n = 0; n < 3; n++) begin
      issue(va[n], vb[n], 1'b1);
      wait_result(lat);
      n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL approx_latency[%0d]: got %0d expected 17", n, lat); end
      n_checks++; if (Y !== ve[n]) begin n_fail++; $display("[TB] FAIL approx_y[%0d]: got %h expected %h", n, Y, ve[n]); end
      consume();
    end
  endtask

  task automatic test_exact_row();
    logic [7:0]  va [4] = '{8'hC0, 8'hC0, 8'd2, 8'd2};
    logic [7:0]  vb [4] = '{8'h03, 8'h03, 8'd2, 8'd2};
    logic        vm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ve [4] = '{16'd576, 16'd576, 16'd4, 16'd4};
    int lat;
    for (int n = 0; n < 4; n++) begin
      issue(va[n], vb[n], vm[n]);
      wait_result(lat);
      n_checks++; if (Y !== ve[n]) begin n_fail++; $display("[TB] FAIL row_y[%0d]: got %h expected %h", n, Y, ve[n]); end
      consume();
    end
  endtask

  task automatic test_ignore_in_run();
    int lat;
    bit bad;
    issue(8'h5A, 8'h3C, 1'b0);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; mode = 1'b1;
    bad = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) bad = 1'b1;
      step(); lat++;
    end
    in_valid = 1'b0;
    n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL run_ignore_ready: got 1 expected 0"); end
    n_checks++; if (Y !== 16'h1518) begin n_fail++; $display("[TB] FAIL run_ignore_y: got %h expected 1518", Y); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bad;
    issue(8'h9B, 8'h47, 1'b0);
    wait_result(lat);
    n_checks++; if (Y !== 16'h2AFD) begin n_fail++; $display("[TB] FAIL bp_y: got %h expected 2afd", Y); end
    in_valid = 1'b1; a = 8'h11; b = 8'h22; mode = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid !== 1'b1 || Y !== 16'h2AFD || in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL bp_stall: out_valid=%b y=%h in_ready=%b expected 1/2afd/0", out_valid, Y, in_ready); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_run: busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    n_checks++; if (Y !== 16'h2AFD) begin n_fail++; $display("[TB] FAIL b2b_y_hold_run: got %h expected 2afd", Y); end
    wait_result(lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected 17", lat); end
    n_checks++; if (Y !== 16'h0242) begin n_fail++; $display("[TB] FAIL b2b_y: got %h expected 0242", Y); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    issue(8'hFF, 8'hFF, 1'b1);
    for (int c = 0; c < 7; c++) step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flags: out_valid=%b busy=%b expected 0/0", out_valid, busy); end
    n_checks++; if (Y !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_y: got %h expected 0000", Y); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_in_ready: got %b expected 0", in_ready); end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_idle: got %b expected 1", in_ready); end
    issue(8'h12, 8'h34, 1'b0);
    wait_result(lat);
    n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL abort_next_latency: got %0d expected 17", lat); end
    n_checks++; if (Y !== 16'd936) begin n_fail++; $display("[TB] FAIL abort_next_y: got %h expected 03a8", Y); end
    consume();
  endtask

  task automatic test_random();
    logic [7:0]  ta, tb;
    logic        tm;
    logic [15:0] exp_y;
    int lat, gap;
    bit bad;
    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      ta = 8'($urandom); tb = 8'($urandom); tm = 1'($urandom);
      exp_y = model(ta, tb, tm);
      issue(ta, tb, tm);
      bad = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
        in_valid = 1'($urandom);
        #1;
        if (in_ready !== 1'b0) bad = 1'b1;
        step(); lat++;
      end
      in_valid = 1'b0;
      n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL rnd_ready_run[%0d]: got 1 expected 0", n); end
      n_checks++; if (lat != 17) begin n_fail++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected 17", n, lat); end
      n_checks++; if (Y !== exp_y) begin n_fail++; $display("[TB] FAIL rnd_y[%0d] a=%h b=%h m=%b: got %h expected %h", n, ta, tb, tm, Y, exp_y); end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_exact_row();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
